fft_frame_serializer: RTL
=========================

FFT_FRAME_SERIALIZER -- requirements
Module: fft_frame_serializer

Interface
- REQ-001: The block SHALL have parameter N, default 8, which is the number of complex points per frame; only 8 is supported.
- REQ-002: The block SHALL have parameter W, default 16, which is the sample word width (IEEE half-precision).
- REQ-003: The ports SHALL be as follows, clock and reset first:
  - clk, input, 1: the only clock; all logic is on its rising edge.
  - rst, input, 1: synchronous reset, active-high.
  - fft_valid, input, 1: a parallel frame is present on the inputs.
  - fft_ready, output, 1: the block accepts a frame this cycle.
  - fftorifft, input, 1: mode tag of the offered frame (0 = FFT, 1 = IFFT).
  - invalid_input, input, 1: the offered frame is flagged invalid.
  - real_in[0:7], input, W each: real parts, natural order.
  - imag_in[0:7], input, W each: imaginary parts, natural order.
  - out_valid, output, 1: a serial beat is present.
  - out_ready, input, 1: the sink accepts the beat.
  - out_real, output, W: real part of the current point.
  - out_imag, output, W: imaginary part of the current point.
  - out_index, output, 3: point index, 0..7.
  - out_last, output, 1: this beat carries point 7.
  - out_mode, output, 1: captured fftorifft of the current frame.
  - drop_count, output, 8: saturating count of dropped invalid frames.

Function
- REQ-004: The block SHALL be a two-state FSM with states IDLE and STREAM, plus a 3-bit index counter idx.
- REQ-005: A frame SHALL be accepted on any rising edge where fft_valid=1 and fft_ready=1.
- REQ-006: fft_ready SHALL be combinational and equal 1 when the state is IDLE, or when the state is STREAM with idx=7 and out_ready=1; it SHALL be 0 otherwise.
- REQ-007: An accepted frame with invalid_input=0 SHALL have all 16 words and fftorifft captured into internal registers; the FSM SHALL enter STREAM with idx=0.
- REQ-008: An accepted frame with invalid_input=1 SHALL NOT be captured; drop_count SHALL increment, saturating at 255, and the FSM SHALL go to (or stay in) IDLE.
- REQ-009: Latency SHALL be one cycle: out_valid=1 in the cycle after the accepting edge.
- REQ-010: In STREAM, the block SHALL drive the following:
  - out_valid=1.
  - out_real and out_imag equal to the buffered real and imaginary words at idx.
  - out_index=idx.
  - out_last=1 exactly when idx=7.
  - out_mode equal to the captured tag.
- REQ-011: A beat SHALL transfer on an edge where out_valid=1 and out_ready=1; idx SHALL then increment by 1, wrapping from 7 to 0.
- REQ-012: While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable and idx SHALL NOT change.
- REQ-013: After the transfer of the idx=7 beat, the FSM SHALL go to IDLE unless a frame is accepted on the same edge.
- REQ-014: When a valid frame is accepted on the same edge as the idx=7 transfer, the FSM SHALL stay in STREAM with idx=0 and the new data, with no idle bubble.
- REQ-015: When an invalid frame is accepted on the same edge as the idx=7 transfer, the FSM SHALL go to IDLE and drop_count SHALL increment.
- REQ-016: In IDLE, out_valid, out_last, out_index, out_real, out_imag and out_mode SHALL all be 0.
- REQ-017: The input arrays SHALL be sampled only on the accepting edge; changes at any other time SHALL have no effect on the streamed data.
- REQ-018: Data words SHALL pass through bit-exact, with no arithmetic, rounding or reordering.

Reset
- REQ-019: While rst=1 at a rising edge, the block SHALL set state=IDLE, idx=0 and drop_count=0, and clear the buffer and captured mode to 0.
- REQ-020: rst SHALL take priority over any simultaneous frame acceptance or beat transfer.
- REQ-021: Reset in the middle of a frame SHALL discard the remainder of that frame.
- REQ-022: fft_ready SHALL equal 1 in the first cycle after reset is released.

Verification
- REQ-023: Single frame: send real_in[k]=16'h4000+k, imag_in[k]=16'h8000+k, fftorifft=1, and hold out_ready=1. The bench SHALL see 8 beats on consecutive cycles, with out_index 0..7, out_real 16'h4000..16'h4007, out_mode=1, and out_last only on the 8th beat.
- REQ-024: Backpressure: drive out_ready=0 for 3 cycles at idx=4. The bench SHALL see out_real=16'h4004 held stable for those 3 cycles and fft_ready=0, with no beat lost or duplicated.
- REQ-025: Back-to-back: hold a second frame (real 16'h3C00+k) valid during the first frame's last beat. The bench SHALL see its idx=0 beat in the very next cycle, giving 16 consecutive beats.
- REQ-026: Invalid frame: offer a frame with invalid_input=1 three times in IDLE. The bench SHALL see drop_count=3 and out_valid stay at 0; after 258 drops, drop_count SHALL read 255.
- REQ-027: Mid-frame reset: assert rst at idx=5. The bench SHALL see out_valid=0, drop_count=0 and fft_ready=1 on the next cycle, and a following frame SHALL stream from idx=0.

Source files
------------

// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer
// Takes one parallel frame of eight complex half-precision points from an FFT
// or IFFT core and replays it as eight serial beats on a valid/ready stream.
// Frames flagged invalid are dropped and counted with a saturating counter.
// The next frame can be accepted on the same edge as the last beat of the
// current frame, so frames can stream back to back without a gap.

module fft_frame_serializer #(
    parameter int N = 8,    // points per frame; the 3-bit index fixes this at 8
    parameter int W = 16    // sample word width (IEEE half-precision)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fft_valid,
    output logic         fft_ready,
    input  logic         fftorifft,
    input  logic         invalid_input,
    input  logic [W-1:0] real_in [0:N-1],
    input  logic [W-1:0] imag_in [0:N-1],
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_real,
    output logic [W-1:0] out_imag,
    output logic [2:0]   out_index,
    output logic         out_last,
    output logic         out_mode,
    output logic [7:0]   drop_count
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [2:0]   idx;
    logic [2:0]   idx_next;

    // Captured frame; it changes only on an accepting edge, so input
    // wiggles outside that edge never reach the stream.
    logic [W-1:0] real_buf [0:N-1];
    logic [W-1:0] imag_buf [0:N-1];
    logic         mode_reg;

    logic         beat;
    logic         last_beat;
    logic         accept;
    logic         capture;
    logic         drop;

    // Handshake decode: a beat leaves whenever the sink is ready while
    // streaming. A new frame is taken in IDLE, or exactly when the final beat
    // leaves, which avoids an idle bubble between consecutive frames.
    always_comb begin
        beat      = (state == STREAM) && out_ready;
        last_beat = beat && (idx == 3'd7);
        fft_ready = (state == IDLE) || last_beat;
        accept    = fft_valid && fft_ready;
        capture   = accept && !invalid_input;
        drop      = accept && invalid_input;
    end

    // State and index register; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 3'd0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state logic: a captured frame always restarts at point 0, while an
    // invalid frame never leaves the block streaming.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    state_next = STREAM;
                    idx_next   = 3'd0;
                end
            end
            STREAM: begin
                if (beat) begin
                    idx_next = idx + 3'd1;
                end
                if (last_beat) begin
                    state_next = capture ? STREAM : IDLE;
                end
                if (capture) begin
                    idx_next = 3'd0;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 3'd0;
            end
        endcase
    end

    // Output decode: while streaming, present the buffered point at idx;
    // otherwise every stream output is held at zero.
    always_comb begin
        out_valid = 1'b0;
        out_real  = '0;
        out_imag  = '0;
        out_index = 3'd0;
        out_last  = 1'b0;
        out_mode  = 1'b0;
        if (state == STREAM) begin
            out_valid = 1'b1;
            out_real  = real_buf[idx];
            out_imag  = imag_buf[idx];
            out_index = idx;
            out_last  = (idx == 3'd7);
            out_mode  = mode_reg;
        end
    end

    // Frame buffer: words are copied bit-exact, only on a valid accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                real_buf[i] <= '0;
                imag_buf[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < N; i++) begin
                real_buf[i] <= real_in[i];
                imag_buf[i] <= imag_in[i];
            end
        end
    end

    // Mode tag travels with the frame it was captured with.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg <= 1'b0;
        end else if (capture) begin
            mode_reg <= fftorifft;
        end
    end

    // Dropped-frame counter, saturating at 255 so it never wraps to look healthy.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= 8'd0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule
